// File: rtl/hbridge_gate_driver_pkg.sv
// Shared types for the H-bridge gate driver: FSM states, leg requests and
// H_IN bit positions.
package motor_pkg;

   typedef enum logic [2:0] {
      COAST   = 3'd0,
      FWD     = 3'd1,
      REV     = 3'd2,
      BRAKE   = 3'd3,
      SWITCH  = 3'd4,
      FAULTED = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } leg_req_t;

   localparam int unsigned AH = 0;
   localparam int unsigned AL = 1;
   localparam int unsigned BH = 2;
   localparam int unsigned BL = 3;

endpackage

// File: rtl/hbridge_gate_driver_deadtime_leg.sv
// One half-bridge leg: registered high/low gates with a dead-time gap
// enforced after every turn-off. Turn-off is immediate; turn-on waits.
module hbridge_deadtime_leg
   import motor_pkg::*;
#(
   parameter int unsigned DEADTIME = 20
) (
   input  logic     PCLK,
   input  logic     PRESET,
   input  leg_req_t REQ,
   output logic     GATE_HI,
   output logic     GATE_LO
);

   localparam int unsigned CW = $clog2(DEADTIME + 1);

   logic [CW-1:0] cnt;
   logic          ready;
   logic          keep_on;

   // The counter reaches 0 on the same edge the gate turns on, so a
   // commutation yields exactly DEADTIME off cycles.
   always_comb begin
      ready   = (cnt <= CW'(1));
      keep_on = (REQ == HIGH && GATE_HI) || (REQ == LOW && GATE_LO);
   end

   // Gate registers and dead-time counter.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         GATE_HI <= 1'b0;
         GATE_LO <= 1'b0;
         cnt     <= CW'(DEADTIME);
      end else if (GATE_HI || GATE_LO) begin
         if (!keep_on) begin
            GATE_HI <= 1'b0;
            GATE_LO <= 1'b0;
            cnt     <= CW'(DEADTIME);
         end
      end else begin
         if (REQ != OFF && ready) begin
            GATE_HI <= (REQ == HIGH);
            GATE_LO <= (REQ == LOW);
         end
         if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/hbridge_gate_driver.sv
// H-bridge gate driver: direction/brake/fault FSM with reversal coast,
// feeding two dead-time protected legs.
module hbridge_gate_driver
   import motor_pkg::*;
#(
   parameter int unsigned DEADTIME       = 20,
   parameter int unsigned REVERSAL_COAST = 2000,
   parameter int unsigned CNT_W          = 12
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       PWM_IN,
   input  logic       DIR_CMD,
   input  logic       BRAKE_CMD,
   input  logic       ENABLE,
   input  logic       FAULT_IN,
   output logic [3:0] H_IN,
   output logic [2:0] STATE,
   output logic       FAULT
);

   state_t     state_q;
   logic       fault_q;
   logic [CNT_W-1:0] rev_cnt;
   leg_req_t   req_a;
   leg_req_t   req_b;
   leg_req_t   pwm_side;
   logic       a_hi, a_lo, b_hi, b_lo;

   // Mode FSM, reversal coast counter and fault latch.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= COAST;
         fault_q <= 1'b0;
         rev_cnt <= '0;
      end else if (FAULT_IN) begin
         state_q <= FAULTED;
         fault_q <= 1'b1;
      end else if (state_q == FAULTED) begin
         if (!ENABLE) begin
            state_q <= COAST;
            fault_q <= 1'b0;
         end
      end else if (!ENABLE) begin
         state_q <= COAST;
      end else if (BRAKE_CMD) begin
         state_q <= BRAKE;
      end else begin
         case (state_q)
            COAST, BRAKE: state_q <= DIR_CMD ? REV : FWD;
            FWD: begin
               if (DIR_CMD) begin
                  state_q <= SWITCH;
                  rev_cnt <= CNT_W'(REVERSAL_COAST - 1);
               end
            end
            REV: begin
               if (!DIR_CMD) begin
                  state_q <= SWITCH;
                  rev_cnt <= CNT_W'(REVERSAL_COAST - 1);
               end
            end
            SWITCH: begin
               if (rev_cnt == '0) begin
                  state_q <= DIR_CMD ? REV : FWD;
               end else begin
                  rev_cnt <= rev_cnt - 1'b1;
               end
            end
            default: state_q <= COAST;
         endcase
      end
   end

   // Leg requests decoded from the current mode and the PWM level.
   always_comb begin
      pwm_side = PWM_IN ? HIGH : LOW;
      req_a    = OFF;
      req_b    = OFF;
      case (state_q)
         FWD: begin
            req_a = pwm_side;
            req_b = LOW;
         end
         REV: begin
            req_a = LOW;
            req_b = pwm_side;
         end
         BRAKE: begin
            req_a = LOW;
            req_b = LOW;
         end
         default: begin
            req_a = OFF;
            req_b = OFF;
         end
      endcase
   end

   hbridge_deadtime_leg #(.DEADTIME(DEADTIME)) u_leg_a (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .REQ     (req_a),
      .GATE_HI (a_hi),
      .GATE_LO (a_lo)
   );

   hbridge_deadtime_leg #(.DEADTIME(DEADTIME)) u_leg_b (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .REQ     (req_b),
      .GATE_HI (b_hi),
      .GATE_LO (b_lo)
   );

   // Gate bus assembly and status outputs.
   always_comb begin
      H_IN     = '0;
      H_IN[AH] = a_hi;
      H_IN[AL] = a_lo;
      H_IN[BH] = b_hi;
      H_IN[BL] = b_lo;
      STATE    = state_q;
      FAULT    = fault_q;
   end

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Directed and random bench for hbridge_gate_driver (DEADTIME=4,
// REVERSAL_COAST=10) with a scoreboard of expected outputs.
module tb_hbridge_gate_driver;
   import motor_pkg::*;

   logic       PCLK = 1'b0;
   logic       PRESET, PWM_IN, DIR_CMD, BRAKE_CMD, ENABLE, FAULT_IN;
   logic [3:0] H_IN;
   logic [2:0] STATE;
   logic       FAULT;

   typedef struct {
      string       tag;
      int unsigned kind;
      logic [3:0]  val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;

   hbridge_gate_driver #(
      .DEADTIME       (4),
      .REVERSAL_COAST (10),
      .CNT_W          (12)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .PWM_IN    (PWM_IN),
      .DIR_CMD   (DIR_CMD),
      .BRAKE_CMD (BRAKE_CMD),
      .ENABLE    (ENABLE),
      .FAULT_IN  (FAULT_IN),
      .H_IN      (H_IN),
      .STATE     (STATE),
      .FAULT     (FAULT)
   );

   always #5 PCLK = ~PCLK;

   task automatic exp_h(input string tag, input logic [3:0] v);
      sb.push_back('{tag, 0, v});
   endtask

   task automatic exp_state(input string tag, input state_t s);
      sb.push_back('{tag, 1, {1'b0, s}});
   endtask

   task automatic exp_fault(input string tag, input logic f);
      sb.push_back('{tag, 2, {3'b000, f}});
   endtask

   task automatic check_sb();
      exp_t       e;
      logic [3:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       obs = H_IN;
            1:       obs = {1'b0, STATE};
            default: obs = {3'b000, FAULT};
         endcase
         n_checks++;
         assert (obs === e.val) n_pass++;
         else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
      check_sb();
   endtask

   // Shoot-through invariants, sampled mid-cycle.
   always @(negedge PCLK) begin
      if (mon_en) begin
         n_checks++;
         assert ((H_IN[AH] & H_IN[AL]) === 1'b0) n_pass++;
         else $error("FAIL shoot_a: observed H_IN=%b expected AH&AL=0", H_IN);
         n_checks++;
         assert ((H_IN[BH] & H_IN[BL]) === 1'b0) n_pass++;
         else $error("FAIL shoot_b: observed H_IN=%b expected BH&BL=0", H_IN);
         n_checks++;
         assert ((H_IN[AH] & H_IN[BH]) === 1'b0) n_pass++;
         else $error("FAIL shoot_hh: observed H_IN=%b expected AH&BH=0", H_IN);
      end
   end

   initial begin
      PRESET = 1'b1; ENABLE = 1'b0; DIR_CMD = 1'b0; BRAKE_CMD = 1'b0;
      FAULT_IN = 1'b0; PWM_IN = 1'b0;
      tick();
      mon_en = 1'b1;
      exp_h("rst_h", 4'b0000);
      exp_state("rst_state", COAST);
      exp_fault("rst_fault", 1'b0);
      tick();

      // Start-up: dead-time after reset release, then AH+BL.
      PRESET = 1'b0; ENABLE = 1'b1; DIR_CMD = 1'b0; PWM_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) exp_state("start_fwd", FWD);
         exp_h("start_dead", 4'b0000);
         tick();
      end
      exp_h("start_on", 4'b1001);
      tick();

      // PWM falling edge: AH off, 4 dead cycles, AL on.
      PWM_IN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_h("fall_dead", 4'b1000);
         tick();
      end
      exp_h("fall_on", 4'b1010);
      tick();

      // PWM rising edge: symmetric.
      PWM_IN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_h("rise_dead", 4'b1000);
         tick();
      end
      exp_h("rise_on", 4'b1001);
      tick();

      // Reversal FWD->REV with a direction glitch inside the coast.
      DIR_CMD = 1'b1;
      exp_state("sw_enter", SWITCH);
      tick();
      for (int i = 0; i < 9; i++) begin
         if (i == 3) DIR_CMD = 1'b0;
         if (i == 5) DIR_CMD = 1'b1;
         exp_h("sw_coast", 4'b0000);
         exp_state("sw_state", SWITCH);
         tick();
      end
      exp_state("sw_exit", REV);
      exp_h("sw_exit_h", 4'b0000);
      tick();
      for (int i = 0; i < 5 && H_IN !== 4'b0110; i++) tick();
      exp_h("sw_drive", 4'b0110);
      check_sb();

      // Reverse back to FWD.
      DIR_CMD = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      exp_state("back_fwd", FWD);
      exp_h("back_fwd_h", 4'b1001);
      tick();

      // Brake from FWD: BL held, AH off, AL after dead-time.
      BRAKE_CMD = 1'b1;
      exp_state("brk_state", BRAKE);
      exp_h("brk_first", 4'b1001);
      tick();
      for (int i = 0; i < 4; i++) begin
         exp_h("brk_dead", 4'b1000);
         tick();
      end
      exp_h("brk_on", 4'b1010);
      tick();

      // Brake release into REV: leg B commutes with dead-time.
      BRAKE_CMD = 1'b0; DIR_CMD = 1'b1;
      exp_state("rel_state", REV);
      exp_h("rel_first", 4'b1010);
      tick();
      for (int i = 0; i < 4; i++) begin
         exp_h("rel_dead", 4'b0010);
         tick();
      end
      exp_h("rel_on", 4'b0110);
      tick();

      // Single-cycle fault pulse, latch, clear, re-enable.
      FAULT_IN = 1'b1;
      exp_state("flt_state", FAULTED);
      exp_fault("flt_set", 1'b1);
      tick();
      FAULT_IN = 1'b0;
      exp_h("flt_off", 4'b0000);
      exp_fault("flt_hold", 1'b1);
      tick();
      for (int i = 0; i < 4; i++) begin
         exp_h("flt_off_hold", 4'b0000);
         exp_state("flt_state_hold", FAULTED);
         exp_fault("flt_latched", 1'b1);
         tick();
      end
      ENABLE = 1'b0;
      exp_state("flt_clear_state", COAST);
      exp_fault("flt_clear", 1'b0);
      exp_h("flt_clear_h", 4'b0000);
      tick();
      ENABLE = 1'b1;
      exp_state("reen_state", REV);
      tick();
      exp_h("reen_h", 4'b0110);
      tick();

      // Reset in the middle of driving.
      PRESET = 1'b1;
      exp_h("mid_rst_h", 4'b0000);
      exp_state("mid_rst_state", COAST);
      exp_fault("mid_rst_fault", 1'b0);
      tick();
      PRESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_h("mid_rst_dead", 4'b0000);
         tick();
      end
      exp_h("mid_rst_on", 4'b0110);
      tick();

      // Random stress; the invariant monitor does the checking.
      for (int i = 0; i < 20000; i++) begin
         PRESET   = ($urandom_range(0, 499) == 0);
         FAULT_IN = ($urandom_range(0, 199) == 0);
         ENABLE   = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 49) == 0) BRAKE_CMD = ~BRAKE_CMD;
         if ($urandom_range(0, 299) == 0) DIR_CMD = ~DIR_CMD;
         if ($urandom_range(0, 7) == 0) PWM_IN = ~PWM_IN;
         tick();
      end

      @(negedge PCLK);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
